// File: rtl/masked_sbox_sched_if.sv
// masked_sbox_sched_if: share bus between the nibble scheduler and one masked S-box stage
interface masked_sbox_sched_if;
    logic [3:0]  sbox_in1, sbox_in2, sbox_in3;
    logic [17:0] sbox_r;
    logic [5:0]  sbox_rs;
    logic [3:0]  sbox_out1, sbox_out2, sbox_out3;
    modport master (output sbox_in1, sbox_in2, sbox_in3, sbox_r, sbox_rs,
                    input  sbox_out1, sbox_out2, sbox_out3);
    modport slave  (input  sbox_in1, sbox_in2, sbox_in3, sbox_r, sbox_rs,
                    output sbox_out1, sbox_out2, sbox_out3);
endinterface

// File: rtl/masked_sbox_sched.sv
// masked_sbox_sched: streams a three-share 64-bit state through one masked S-box, a nibble per feed.
// Define SBOX_PRNG_EN for an internal LFSR randomness source instead of the rnd_in handshake.
module masked_sbox_sched #(
    parameter int NIB      = 16,
    parameter int SBOX_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] state_in1,
    input  logic [63:0] state_in2,
    input  logic [63:0] state_in3,
    output logic        busy,
    output logic        done,
    output logic [63:0] state_out1,
    output logic [63:0] state_out2,
    output logic [63:0] state_out3,
`ifdef SBOX_PRNG_EN
    input  logic [31:0] seed,
    input  logic        seed_load,
`else
    input  logic [23:0] rnd_in,
    input  logic        rnd_valid,
    output logic        rnd_ready,
`endif
    masked_sbox_sched_if.master sb
);
    typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;
    localparam logic [SBOX_LAT-1:0] TOP = SBOX_LAT'(1) << (SBOX_LAT - 1);

    state_t              st;
    logic [63:0]         b1, b2, b3;
    logic [3:0]          k;
    logic [SBOX_LAT-1:0] vld;
    logic [3:0]          idx [SBOX_LAT];
    logic                feed, wb, last;
    logic [23:0]         rnd;

`ifdef SBOX_PRNG_EN
    logic [31:0] lfsr, lfsr_nxt;
    always_comb begin
        lfsr_nxt = lfsr;
        for (int i = 0; i < 24; i++)
            lfsr_nxt = {lfsr_nxt[30:0], lfsr_nxt[31] ^ lfsr_nxt[21] ^ lfsr_nxt[1] ^ lfsr_nxt[0]};
    end
    assign rnd  = lfsr_nxt[23:0];
    assign feed = st == FEED;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) lfsr <= 32'h1;
        else if (seed_load) lfsr <= seed == '0 ? 32'h1 : seed;
        else if (feed) lfsr <= lfsr_nxt;
`else
    assign rnd       = rnd_in;
    assign feed      = st == FEED && rnd_valid;
    assign rnd_ready = feed;
`endif

    // Non-feed cycles present all-zero shares so no stale share reaches the stage
    assign sb.sbox_in1 = feed ? b1[{k, 2'b00} +: 4] : '0;
    assign sb.sbox_in2 = feed ? b2[{k, 2'b00} +: 4] : '0;
    assign sb.sbox_in3 = feed ? b3[{k, 2'b00} +: 4] : '0;
    assign sb.sbox_r   = feed ? rnd[17:0]  : '0;
    assign sb.sbox_rs  = feed ? rnd[23:18] : '0;

    assign wb   = vld[SBOX_LAT-1];
    assign last = vld == TOP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= IDLE;
            k          <= '0;
            b1         <= '0;
            b2         <= '0;
            b3         <= '0;
            vld        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            state_out1 <= '0;
            state_out2 <= '0;
            state_out3 <= '0;
            for (int i = 0; i < SBOX_LAT; i++) idx[i] <= '0;
        end else begin
            done   <= 1'b0;
            vld    <= SBOX_LAT'({vld, feed});
            idx[0] <= k;
            for (int i = 1; i < SBOX_LAT; i++) idx[i] <= idx[i-1];
            if (wb) begin
                state_out1[{idx[SBOX_LAT-1], 2'b00} +: 4] <= sb.sbox_out1;
                state_out2[{idx[SBOX_LAT-1], 2'b00} +: 4] <= sb.sbox_out2;
                state_out3[{idx[SBOX_LAT-1], 2'b00} +: 4] <= sb.sbox_out3;
            end
            if (st == IDLE && start) begin
                b1   <= state_in1;
                b2   <= state_in2;
                b3   <= state_in3;
                k    <= '0;
                busy <= 1'b1;
                st   <= FEED;
            end else if (feed) begin
                k  <= k + 4'd1;
                st <= k == 4'(NIB - 1) ? DRAIN : FEED;
            end else if (st == DRAIN && last) begin
                done <= 1'b1;
                busy <= 1'b0;
                st   <= IDLE;
            end
        end
    end
endmodule

// File: doc/masked_sbox_sched.md
# masked_sbox_sched

Sequencer that streams one 64-bit, three-share Midori state through a single shared second-order masked 4-bit S-box stage, one nibble per cycle. It supplies fresh randomness to the stage on every feed cycle and tracks the stage's one-cycle register latency. It reassembles the 16 result nibbles into three output shares. It sits between the round controller and the masked S-box instance in the serial cipher datapath.

## Interface
- NIB, 16, nibbles per state (fixed for Midori-64)
- SBOX_LAT, 1, S-box stage register latency in cycles
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a pass; sampled only in IDLE
- state_in1/2/3  in  64  input shares; nibble k = bits [4k+3:4k]
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse; state_out valid
- state_out1/2/3  out  64  result shares, held until the next accepted start
- sbox_in1/2/3  out  4  to S-box shares
- sbox_r  out  18  to S-box r
- sbox_rs  out  6  to S-box rs
- sbox_out1/2/3  in  4  from S-box, SBOX_LAT cycles after the matching sbox_in
- seed  in  32  PRNG seed (SBOX_PRNG_EN only)
- seed_load  in  1  load seed (SBOX_PRNG_EN only)
- rnd_in  in  24  external randomness {rs, r} (no SBOX_PRNG_EN)
- rnd_valid  in  1  rnd_in valid (no SBOX_PRNG_EN)
- rnd_ready  out  1  rnd_in consumed this cycle (no SBOX_PRNG_EN)

## Operation
- FSM: IDLE -> FEED -> DRAIN -> IDLE.
- IDLE, start=1: capture state_in1/2/3 into input buffers, clear nibble counter k, go to FEED. start while busy is ignored.
- FEED: a feed cycle occurs when randomness is available. With the PRNG this is every cycle; externally it requires rnd_valid=1.
  - On a feed cycle, drive nibble k of each share on sbox_in1/2/3 and the fresh 24 bits on {sbox_rs, sbox_r}, then increment k.
  - After the feed of k=15, go to DRAIN.
- Non-feed cycles: sbox_in*, sbox_r and sbox_rs are driven to 0. No stale share reaches the stage.
- Write-back: a SBOX_LAT-deep valid/index pipeline follows each feed. When it emerges, sbox_out1/2/3 are written to nibble index of state_out1/2/3.
- DRAIN: stay until the last write-back lands, then pulse done, clear busy, return to IDLE.
- Shares are never recombined inside the block.
- rst_n low: FSM to IDLE; counter, buffers, valid pipeline and all outputs go to 0; the LFSR goes to 32'h00000001. Reset takes effect immediately, including mid-pass. No partial result survives.

## Timing
- Accepted start at edge E0. Feed k is presented in the cycle after E(k), with no stalls.
- Write-back of nibble k happens at E(k+1+SBOX_LAT).
- done is high in the cycle after E16+SBOX_LAT, i.e. 17 cycles after E0 with SBOX_LAT=1. busy falls on the same edge.
- Each stalled cycle (rnd_valid=0 in FEED) adds exactly one cycle. In-flight write-backs still complete during stalls.
- A new start is accepted in the cycle done is high. Back-to-back passes therefore have a period of 18 cycles.
- rnd_ready = (state==FEED) & rnd_valid. It is combinational and never high outside FEED.

## Configuration
- SBOX_PRNG_EN defined: internal 32-bit Fibonacci LFSR, taps 32,22,2,1.
  - It advances 24 steps per feed cycle; {sbox_rs, sbox_r} = low 24 bits of the new state.
  - seed_load in any state loads seed; a seed of 0 is replaced by 32'h00000001.
  - FEED never stalls. rnd_in, rnd_valid and rnd_ready are absent.
- SBOX_PRNG_EN undefined: no LFSR; randomness comes from rnd_in with the valid/ready handshake. seed and seed_load are absent.

## Test plan
- Reset: hold rst_n=0 with start=1 -> busy=0, done=0, state_out*=0, sbox_in*=0, sbox_r=0, sbox_rs=0.
- Identity stub (1-cycle register), state_in1=64'h0123456789ABCDEF, in2=in3=0 -> done exactly 17 cycles after the start edge; state_out1=64'h0123456789ABCDEF, out2=out3=0.
- External randomness (no macro): rnd_valid=0 for 5 cycles after the 4th feed, same data -> done at cycle 22; identical result; rnd_ready high on exactly 16 cycles.
- Real masked F stage, random input shares -> the XOR of output shares equals the unmasked reference F applied per nibble, over 1000 passes; sbox_in*=0 on every non-feed cycle.
- start pulsed at cycle 5 of a pass -> ignored; rst_n low at cycle 8 -> next cycle in IDLE with outputs 0; a fresh pass then completes correctly.
- PRNG (macro): seed=0 with seed_load -> LFSR=1; {sbox_rs, sbox_r} differs between consecutive feed cycles and is never all-zero over 16 feeds.
